// File: rtl/mt_branch_resolve.sv
// Execute-stage branch/jump resolver with per-thread wrong-path shadow squash.
// Optional MT_BR_STATS_EN adds per-thread saturating taken-redirect counters and a stat read port.
module mt_branch_resolve #(
  parameter int NUM_THREADS   = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PIPE_SHADOW   = 0,
  localparam int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_e,
  input  logic [DATA_WIDTH-1:0]    imm_e,
  input  logic [DATA_WIDTH-1:0]    rs1_val_e,
  input  logic [DATA_WIDTH-1:0]    rs2_val_e,
  input  logic [2:0]               funct3_e,
  input  logic                     branch_e,
  input  logic                     jal_e,
  input  logic                     jalr_e,
`ifdef MT_BR_STATS_EN
  input  logic [BITS_THREADS-1:0]  stat_tid,
  output logic [15:0]              stat_count,
`endif
  output logic                     pc_src_e,
  output logic [BITS_THREADS-1:0]  branch_tid_e,
  output logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     squash_e,
  output logic                     misalign_e,
  output logic                     illegal_e
);

  localparam logic [1:0] SHADOW_LOAD = 2'(PIPE_SHADOW);

  logic [1:0]               shadow_q [NUM_THREADS];
  logic [1:0]               shadow_d [NUM_THREADS];
  logic                     pc_src_q, pc_src_d;
  logic [BITS_THREADS-1:0]  branch_tid_q, branch_tid_d;
  logic [ADDRESS_WIDTH-1:0] pc_target_q, pc_target_d;
  logic                     misalign_q, misalign_d;
  logic                     illegal_q, illegal_d;

  logic                     live;
  logic                     cond;
  logic                     funct3_bad;
  logic                     taken;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] imm_a;
  logic [ADDRESS_WIDTH-1:0] rs1_a;
  logic [ADDRESS_WIDTH-1:0] target;

  assign squash_e = valid_e & (shadow_q[tid_e] != 2'd0);
  assign live     = valid_e & ~squash_e;

  assign imm_a = ADDRESS_WIDTH'(imm_e);
  assign rs1_a = ADDRESS_WIDTH'(rs1_val_e);

  always_comb begin
    cond       = 1'b0;
    funct3_bad = 1'b0;
    case (funct3_e)
      3'b000:  cond = (rs1_val_e == rs2_val_e);
      3'b001:  cond = (rs1_val_e != rs2_val_e);
      3'b100:  cond = ($signed(rs1_val_e) <  $signed(rs2_val_e));
      3'b101:  cond = ($signed(rs1_val_e) >= $signed(rs2_val_e));
      3'b110:  cond = (rs1_val_e <  rs2_val_e);
      3'b111:  cond = (rs1_val_e >= rs2_val_e);
      default: funct3_bad = 1'b1;
    endcase
  end

  // JALR clears bit0 only; bit1 survives so misaligned JALR targets are flagged.
  always_comb begin
    if (jalr_e) target = (rs1_a + imm_a) & ~ADDRESS_WIDTH'(1);
    else        target = pc_e + imm_a;
  end

  assign taken    = live & ((branch_e & cond) | jal_e | jalr_e);
  assign redirect = taken & ~target[1];

  always_comb begin
    pc_src_d     = redirect;
    branch_tid_d = branch_tid_q;
    pc_target_d  = pc_target_q;
    misalign_d   = taken & target[1];
    illegal_d    = live & branch_e & funct3_bad;
    if (redirect) begin
      branch_tid_d = tid_e;
      pc_target_d  = target;
    end
  end

  // A squashed instruction never redirects, so load and decrement cannot
  // really collide; load is still given priority explicitly.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) shadow_d[i] = shadow_q[i];
    if (squash_e) shadow_d[tid_e] = shadow_q[tid_e] - 2'd1;
    if (redirect) shadow_d[tid_e] = SHADOW_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_src_q     <= 1'b0;
      branch_tid_q <= '0;
      pc_target_q  <= '0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) shadow_q[i] <= 2'd0;
    end else begin
      pc_src_q     <= pc_src_d;
      branch_tid_q <= branch_tid_d;
      pc_target_q  <= pc_target_d;
      misalign_q   <= misalign_d;
      illegal_q    <= illegal_d;
      for (int i = 0; i < NUM_THREADS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign pc_src_e     = pc_src_q;
  assign branch_tid_e = branch_tid_q;
  assign pc_target_e  = pc_target_q;
  assign misalign_e   = misalign_q;
  assign illegal_e    = illegal_q;

`ifdef MT_BR_STATS_EN
  logic [15:0] stat_q [NUM_THREADS];
  logic [15:0] stat_d [NUM_THREADS];

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) stat_d[i] = stat_q[i];
    if (redirect && (stat_q[tid_e] != 16'hFFFF)) stat_d[tid_e] = stat_q[tid_e] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) stat_q[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stat_count = stat_q[stat_tid];
`endif

endmodule

// File: tb/tb_mt_branch_resolve.sv
// Bench for mt_branch_resolve: one pure-barrel instance and one with a 2-deep shadow,
// driven by shared stimulus and checked against a per-instance reference model.
module tb_mt_branch_resolve;

  logic        clk;
  logic        rst;
  logic        valid_e;
  logic [2:0]  tid_e;
  logic [31:0] pc_e, imm_e, rs1_v, rs2_v;
  logic [2:0]  f3;
  logic        br, jal, jalr;

  logic        src0, src2, sq0, sq2, mis0, mis2, ill0, ill2;
  logic [2:0]  btid0, btid2;
  logic [31:0] tgt0, tgt2;
`ifdef MT_BR_STATS_EN
  logic [2:0]  stat_tid;
  logic [15:0] stat_cnt0, stat_cnt2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mt_branch_resolve #(.PIPE_SHADOW(0)) dut0 (
    .clk(clk), .rst(rst), .valid_e(valid_e), .tid_e(tid_e), .pc_e(pc_e), .imm_e(imm_e),
    .rs1_val_e(rs1_v), .rs2_val_e(rs2_v), .funct3_e(f3), .branch_e(br), .jal_e(jal), .jalr_e(jalr),
`ifdef MT_BR_STATS_EN
    .stat_tid(stat_tid), .stat_count(stat_cnt0),
`endif
    .pc_src_e(src0), .branch_tid_e(btid0), .pc_target_e(tgt0), .squash_e(sq0),
    .misalign_e(mis0), .illegal_e(ill0));

  mt_branch_resolve #(.PIPE_SHADOW(2)) dut2 (
    .clk(clk), .rst(rst), .valid_e(valid_e), .tid_e(tid_e), .pc_e(pc_e), .imm_e(imm_e),
    .rs1_val_e(rs1_v), .rs2_val_e(rs2_v), .funct3_e(f3), .branch_e(br), .jal_e(jal), .jalr_e(jalr),
`ifdef MT_BR_STATS_EN
    .stat_tid(stat_tid), .stat_count(stat_cnt2),
`endif
    .pc_src_e(src2), .branch_tid_e(btid2), .pc_target_e(tgt2), .squash_e(sq2),
    .misalign_e(mis2), .illegal_e(ill2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, index 0 = shadow depth 0, index 1 = shadow depth 2
  int          shadow_depth [2] = '{0, 2};
  int          sh   [2][8];
  logic        e_src [2], e_mis [2], e_ill [2];
  logic [2:0]  e_tid [2];
  logic [31:0] e_tgt [2];
  logic        seen_sq [2];

  typedef struct {
    logic        valid;
    logic [2:0]  tid;
    logic [31:0] pc, imm, rs1, rs2;
    logic [2:0]  f3;
    logic        br, jal, jalr;
    logic        x_src;
    logic [2:0]  x_tid;
    logic [31:0] x_tgt;
    logic        x_mis, x_ill;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic isbr, input logic isjal, input logic isjalr);
    valid_e = v; tid_e = t; pc_e = p; imm_e = i; rs1_v = a; rs2_v = b;
    f3 = f; br = isbr; jal = isjal; jalr = isjalr;
  endtask

  // One cycle: check squash before the edge, advance the model, check registered outputs after it.
  task automatic step();
    logic live, tk;
    logic [31:0] target;
    #1;
    for (int k = 0; k < 2; k++) begin
      seen_sq[k] = valid_e && (sh[k][tid_e] != 0);
      chk(k == 0 ? "squash_e[0]" : "squash_e[2]", {31'd0, (k == 0) ? sq0 : sq2}, {31'd0, seen_sq[k]});
      if (rst) begin
        e_src[k] = 0; e_mis[k] = 0; e_ill[k] = 0; e_tid[k] = 0; e_tgt[k] = 0;
        for (int t = 0; t < 8; t++) sh[k][t] = 0;
      end else begin
        live   = valid_e && !seen_sq[k];
        tk     = live && ((br && cond_true(f3, rs1_v, rs2_v)) || jal || jalr);
        target = jalr ? ((rs1_v + imm_e) & 32'hFFFF_FFFE) : (pc_e + imm_e);
        e_ill[k] = live && br && (f3 == 3'd2 || f3 == 3'd3);
        e_src[k] = tk && !target[1];
        e_mis[k] = tk && target[1];
        if (e_src[k]) begin
          e_tid[k] = tid_e;
          e_tgt[k] = target;
          sh[k][tid_e] = shadow_depth[k];
        end else if (seen_sq[k]) begin
          sh[k][tid_e] = sh[k][tid_e] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("pc_src[0]",   {31'd0, src0}, {31'd0, e_src[0]});
    chk("tid[0]",      {29'd0, btid0}, {29'd0, e_tid[0]});
    chk("target[0]",   tgt0, e_tgt[0]);
    chk("misalign[0]", {31'd0, mis0}, {31'd0, e_mis[0]});
    chk("illegal[0]",  {31'd0, ill0}, {31'd0, e_ill[0]});
    chk("pc_src[2]",   {31'd0, src2}, {31'd0, e_src[1]});
    chk("tid[2]",      {29'd0, btid2}, {29'd0, e_tid[1]});
    chk("target[2]",   tgt2, e_tgt[1]);
    chk("misalign[2]", {31'd0, mis2}, {31'd0, e_mis[1]});
    chk("illegal[2]",  {31'd0, ill2}, {31'd0, e_ill[1]});
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
`ifdef MT_BR_STATS_EN
    stat_tid = 3'd4;
`endif
    for (int k = 0; k < 2; k++) begin
      e_src[k] = 0; e_mis[k] = 0; e_ill[k] = 0; e_tid[k] = 0; e_tgt[k] = 0;
      for (int t = 0; t < 8; t++) sh[k][t] = 0;
    end

    //           valid tid pc            imm           rs1           rs2           f3  br jal jalr src tid tgt           mis ill
    tbl[0]  = '{1'b0, 3'd0, 32'h0,        32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 0, 0, 3'd0, 32'h0,    0, 0};
    tbl[1]  = '{1'b1, 3'd3, 32'h100,      32'h20,       32'd5,        32'd5,        3'd0, 1, 0, 0, 1, 3'd3, 32'h120,  0, 0};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 0, 0, 3'd0, 32'h0,    0, 0};
    tbl[3]  = '{1'b1, 3'd0, 32'h200,      32'h40,       32'hFFFF_FFFF, 32'd1,       3'd4, 1, 0, 0, 1, 3'd0, 32'h240,  0, 0};
    tbl[4]  = '{1'b1, 3'd1, 32'h200,      32'h40,       32'hFFFF_FFFF, 32'd1,       3'd6, 1, 0, 0, 0, 3'd0, 32'h0,    0, 0};
    tbl[5]  = '{1'b1, 3'd2, 32'h200,      32'h40,       32'd7,        32'd7,        3'd2, 1, 0, 0, 0, 3'd0, 32'h0,    0, 1};
    tbl[6]  = '{1'b1, 3'd5, 32'h400,      32'h0,        32'h203,      32'h0,        3'd0, 0, 0, 1, 0, 3'd0, 32'h0,    1, 0};
    tbl[7]  = '{1'b1, 3'd5, 32'h400,      32'h0,        32'h201,      32'h0,        3'd0, 0, 0, 1, 1, 3'd5, 32'h200,  0, 0};
    tbl[8]  = '{1'b1, 3'd7, 32'hFFFF_FFF0, 32'h20,      32'h0,        32'h0,        3'd0, 0, 1, 0, 1, 3'd7, 32'h10,   0, 0};
    tbl[9]  = '{1'b1, 3'd4, 32'h100,      32'h20,       32'd3,        32'd3,        3'd1, 1, 0, 0, 0, 3'd0, 32'h0,    0, 0};
    tbl[10] = '{1'b1, 3'd6, 32'h300,      32'hFFFF_FFF8, 32'd1,       32'hFFFF_FFFF, 3'd5, 1, 0, 0, 1, 3'd6, 32'h2F8,  0, 0};
    tbl[11] = '{1'b1, 3'd1, 32'h300,      32'hFFFF_FFF8, 32'd1,       32'hFFFF_FFFF, 3'd7, 1, 0, 0, 0, 3'd0, 32'h0,    0, 0};
    tbl[12] = '{1'b1, 3'd2, 32'h100,      32'h2,        32'd9,        32'd9,        3'd0, 1, 0, 0, 0, 3'd0, 32'h0,    1, 0};
    tbl[13] = '{1'b1, 3'd3, 32'h100,      32'h20,       32'd1,        32'd2,        3'd3, 1, 0, 0, 0, 3'd0, 32'h0,    0, 1};
    tbl[14] = '{1'b0, 3'd4, 32'h100,      32'h20,       32'd1,        32'd1,        3'd0, 1, 1, 0, 0, 3'd0, 32'h0,    0, 0};

    @(negedge clk);
    do_reset(2);
    chk("reset pc_src",   {31'd0, src0}, 32'd0);
    chk("reset target",   tgt0, 32'd0);
    chk("reset tid",      {29'd0, btid0}, 32'd0);
    chk("reset misalign", {31'd0, mis0}, 32'd0);
    chk("reset illegal",  {31'd0, ill0}, 32'd0);
    for (int c = 0; c < 3; c++) step();

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].tid, tbl[i].pc, tbl[i].imm, tbl[i].rs1, tbl[i].rs2,
            tbl[i].f3, tbl[i].br, tbl[i].jal, tbl[i].jalr);
      step();
      chk($sformatf("tbl%0d pc_src", i), {31'd0, src0}, {31'd0, tbl[i].x_src});
      chk($sformatf("tbl%0d misalign", i), {31'd0, mis0}, {31'd0, tbl[i].x_mis});
      chk($sformatf("tbl%0d illegal", i), {31'd0, ill0}, {31'd0, tbl[i].x_ill});
      if (tbl[i].x_src) begin
        chk($sformatf("tbl%0d target", i), tgt0, tbl[i].x_tgt);
        chk($sformatf("tbl%0d tid", i), {29'd0, btid0}, {29'd0, tbl[i].x_tid});
      end
    end
    idle();
    step();
    chk("pulse ends", {31'd0, src0}, 32'd0);
    chk("target held", tgt0, 32'h2F8);

    // shadow depth 2: tid 1 redirected, next two tid-1 instrs squashed, tid 2 unaffected
    do_reset(1);
    drive(1, 1, 32'h0, 32'h40, 0, 0, 0, 0, 1, 0); step();
    chk("sh redirect t1", {31'd0, src2}, 32'd1);
    drive(1, 1, 32'h0, 32'h80, 0, 0, 0, 0, 1, 0); step();
    chk("sh squash 1st", {31'd0, seen_sq[1]}, 32'd1);
    chk("sh no redirect 1st", {31'd0, src2}, 32'd0);
    drive(1, 2, 32'h0, 32'hC0, 0, 0, 0, 0, 1, 0); step();
    chk("sh tid2 live", {31'd0, src2}, 32'd1);
    drive(1, 1, 32'h0, 32'h80, 0, 0, 0, 0, 1, 0); step();
    chk("sh squash 2nd", {31'd0, seen_sq[1]}, 32'd1);
    chk("sh no redirect 2nd", {31'd0, src2}, 32'd0);
    drive(1, 1, 32'h0, 32'h84, 0, 0, 0, 0, 1, 0); step();
    chk("sh third resolves", {31'd0, src2}, 32'd1);
    chk("sh third target", tgt2, 32'h84);

    // reset mid-operation drops a pending pulse and clears shadows
    drive(1, 1, 32'h10, 32'h10, 0, 0, 0, 0, 1, 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst drops pulse", {31'd0, src0}, 32'd0);
    drive(1, 3, 32'h10, 32'h10, 0, 0, 0, 0, 1, 0); step();
    rst = 1'b1; idle(); step(); rst = 1'b0;
    drive(1, 3, 32'h10, 32'h30, 0, 0, 0, 0, 1, 0); step();
    chk("rst clears shadow", {31'd0, src2}, 32'd1);

`ifdef MT_BR_STATS_EN
    do_reset(1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 4, 32'h1000, 32'h10, 0, 0, 0, 0, 1, 0); step();
    end
    idle(); step();
    chk("stat_count t4", {16'd0, stat_cnt0}, 32'd3);
`endif

    // randomized traffic on a few threads so shadows overlap
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      int op;
      logic [31:0] a, b, im;
      op = $urandom_range(0, 5);
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      im = (($urandom_range(0, 1) == 1) ? 32'hFFFF_F000 : 32'h0) | ($urandom & 32'h0000_0FFE);
      drive(op != 5, 3'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, im, a, b,
            3'($urandom_range(0, 7)), op <= 1, op == 2, op == 3);
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
